// File: rtl/cache_pkg.sv
// Shared definitions for the data cache: miss-FSM states, default geometry,
// and helpers that split a byte address into tag / set / word fields.
package cache_pkg;

    localparam int unsigned LINE_ADDR_LEN_DEF = 32'd3;
    localparam int unsigned SET_ADDR_LEN_DEF  = 32'd4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WB     = 2'd1,
        REFILL = 2'd2
    } cache_state_e;

    // Tag field, right-justified: everything above the set and word fields.
    function automatic logic [31:0] addr_tag(input logic [31:0] a,
                                             input int unsigned line_len,
                                             input int unsigned set_len);
        return a >> (line_len + set_len + 32'd2);
    endfunction

    // Set index, right-justified.
    function automatic logic [31:0] addr_set(input logic [31:0] a,
                                             input int unsigned line_len,
                                             input int unsigned set_len);
        return (a >> (line_len + 32'd2)) & ((32'd1 << set_len) - 32'd1);
    endfunction

    // Word-within-line index, right-justified; byte offset is dropped.
    function automatic logic [31:0] addr_word(input logic [31:0] a,
                                              input int unsigned line_len);
        return (a >> 32'd2) & ((32'd1 << line_len) - 32'd1);
    endfunction

endpackage

// File: rtl/dcache_line_ram.sv
// Line storage for the direct-mapped data cache: data words, tags and
// per-set valid/dirty bits. One combinational read port, one byte-enabled
// write port, a line-fill strobe (tag/valid/clean) and a dirty strobe.
module dcache_line_ram
    import cache_pkg::*;
#(
    parameter int unsigned LINE_ADDR_LEN = LINE_ADDR_LEN_DEF,
    parameter int unsigned SET_ADDR_LEN  = SET_ADDR_LEN_DEF,
    parameter int unsigned TAG_ADDR_LEN  = 32'd30 - SET_ADDR_LEN_DEF - LINE_ADDR_LEN_DEF
)(
    input  logic                     clk,
    input  logic                     clr,
    input  logic [SET_ADDR_LEN-1:0]  rd_set,
    input  logic [LINE_ADDR_LEN-1:0] rd_word,
    output logic [31:0]              rd_data,
    output logic [TAG_ADDR_LEN-1:0]  rd_tag,
    output logic                     rd_valid,
    output logic                     rd_dirty,
    input  logic                     wr_en,
    input  logic [3:0]               wr_be,
    input  logic [SET_ADDR_LEN-1:0]  wr_set,
    input  logic [LINE_ADDR_LEN-1:0] wr_word,
    input  logic [31:0]              wr_data,
    input  logic                     fill_en,
    input  logic [TAG_ADDR_LEN-1:0]  fill_tag,
    input  logic                     dirty_en
);

    localparam int unsigned NUM_SETS  = 32'd1 << SET_ADDR_LEN;
    localparam int unsigned NUM_WORDS = 32'd1 << LINE_ADDR_LEN;

    logic [31:0]             data_q [NUM_SETS][NUM_WORDS];
    logic [TAG_ADDR_LEN-1:0] tag_q  [NUM_SETS];
    logic [NUM_SETS-1:0]     valid_q, valid_d;
    logic [NUM_SETS-1:0]     dirty_q, dirty_d;

    assign rd_data  = data_q[rd_set][rd_word];
    assign rd_tag   = tag_q[rd_set];
    assign rd_valid = valid_q[rd_set];
    assign rd_dirty = dirty_q[rd_set];

    // Data words: byte-enabled write; suppressed while the cache is being cleared.
    always_ff @(posedge clk) begin
        if (wr_en && !clr) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    data_q[wr_set][wr_word][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Tags: written only when a refill completes.
    always_ff @(posedge clk) begin
        if (fill_en && !clr) begin
            tag_q[wr_set] <= fill_tag;
        end
    end

    // Next valid/dirty state: a fill validates and cleans a set, a store dirties it.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (fill_en) begin
            valid_d[wr_set] = 1'b1;
            dirty_d[wr_set] = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        if (dirty_en) begin
            dirty_d[wr_set] = 1'b1;
        end else begin
            dirty_d = dirty_d;
        end
    end

    // Valid/dirty registers with synchronous clear; dirty lines are dropped on clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            valid_q <= {NUM_SETS{1'b0}};
            dirty_q <= {NUM_SETS{1'b0}};
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

endmodule

// File: rtl/dcache_miss_ctrl.sv
// Direct-mapped write-back / write-allocate data cache for the MEM stage.
// Raises DCacheMiss while an access cannot complete, writes back a dirty
// victim and refills the line word by word over a req/ack memory handshake.
module dcache_miss_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned LINE_ADDR_LEN = LINE_ADDR_LEN_DEF,
    parameter int unsigned SET_ADDR_LEN  = SET_ADDR_LEN_DEF
)(
    input  logic        clk,
    input  logic        CpuRst,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_be,
    output logic [31:0] rd_data,
    output logic        DCacheMiss,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] miss_cnt
);

    localparam int unsigned TAG_ADDR_LEN = 32'd30 - SET_ADDR_LEN - LINE_ADDR_LEN;

    // Request address fields
    logic [TAG_ADDR_LEN-1:0]  req_tag_s;
    logic [SET_ADDR_LEN-1:0]  req_set_s;
    logic [LINE_ADDR_LEN-1:0] req_word_s;

    // Miss FSM state and latched miss address
    cache_state_e             state_q, state_d;
    logic [LINE_ADDR_LEN-1:0] cnt_q, cnt_d;
    logic [TAG_ADDR_LEN-1:0]  miss_tag_q, miss_tag_d;
    logic [SET_ADDR_LEN-1:0]  miss_set_q, miss_set_d;
    logic [31:0]              miss_cnt_q, miss_cnt_d;

    // Line RAM interface
    logic [SET_ADDR_LEN-1:0]  ram_rd_set_s;
    logic [LINE_ADDR_LEN-1:0] ram_rd_word_s;
    logic [31:0]              ram_rd_data_s;
    logic [TAG_ADDR_LEN-1:0]  ram_rd_tag_s;
    logic                     ram_rd_valid_s;
    logic                     ram_rd_dirty_s;
    logic                     ram_wr_en_s;
    logic [3:0]               ram_wr_be_s;
    logic [SET_ADDR_LEN-1:0]  ram_wr_set_s;
    logic [LINE_ADDR_LEN-1:0] ram_wr_word_s;
    logic [31:0]              ram_wr_data_s;
    logic                     ram_fill_en_s;
    logic                     ram_dirty_en_s;

    logic                     req_s;
    logic                     hit_s;
    logic                     cnt_last_s;

    assign req_tag_s  = TAG_ADDR_LEN'(addr_tag(addr, LINE_ADDR_LEN, SET_ADDR_LEN));
    assign req_set_s  = SET_ADDR_LEN'(addr_set(addr, LINE_ADDR_LEN, SET_ADDR_LEN));
    assign req_word_s = LINE_ADDR_LEN'(addr_word(addr, LINE_ADDR_LEN));

    assign req_s      = rd_req | wr_req;
    assign hit_s      = (state_q == IDLE) && ram_rd_valid_s && (ram_rd_tag_s == req_tag_s);
    assign cnt_last_s = (cnt_q == {LINE_ADDR_LEN{1'b1}});

    assign rd_data    = ram_rd_data_s;
    assign miss_cnt   = miss_cnt_q;

    // Read-port steering: the live request in IDLE, the victim/miss line otherwise.
    always_comb begin
        ram_rd_set_s  = req_set_s;
        ram_rd_word_s = req_word_s;
        if (state_q == IDLE) begin
            ram_rd_set_s  = req_set_s;
            ram_rd_word_s = req_word_s;
        end else begin
            ram_rd_set_s  = miss_set_q;
            ram_rd_word_s = cnt_q;
        end
    end

    dcache_line_ram #(
        .LINE_ADDR_LEN (LINE_ADDR_LEN),
        .SET_ADDR_LEN  (SET_ADDR_LEN),
        .TAG_ADDR_LEN  (TAG_ADDR_LEN)
    ) u_line_ram (
        .clk      (clk),
        .clr      (CpuRst),
        .rd_set   (ram_rd_set_s),
        .rd_word  (ram_rd_word_s),
        .rd_data  (ram_rd_data_s),
        .rd_tag   (ram_rd_tag_s),
        .rd_valid (ram_rd_valid_s),
        .rd_dirty (ram_rd_dirty_s),
        .wr_en    (ram_wr_en_s),
        .wr_be    (ram_wr_be_s),
        .wr_set   (ram_wr_set_s),
        .wr_word  (ram_wr_word_s),
        .wr_data  (ram_wr_data_s),
        .fill_en  (ram_fill_en_s),
        .fill_tag (miss_tag_q),
        .dirty_en (ram_dirty_en_s)
    );

    // Miss FSM next state, line RAM writes and memory-side outputs.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        miss_tag_d     = miss_tag_q;
        miss_set_d     = miss_set_q;
        miss_cnt_d     = miss_cnt_q;
        DCacheMiss     = 1'b0;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = 32'd0;
        mem_wdata      = 32'd0;
        ram_wr_en_s    = 1'b0;
        ram_wr_be_s    = 4'b0000;
        ram_wr_set_s   = req_set_s;
        ram_wr_word_s  = req_word_s;
        ram_wr_data_s  = wr_data;
        ram_fill_en_s  = 1'b0;
        ram_dirty_en_s = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_s && hit_s) begin
                    // A store wins over a simultaneous load.
                    if (wr_req) begin
                        ram_wr_en_s    = 1'b1;
                        ram_wr_be_s    = wr_be;
                        ram_dirty_en_s = 1'b1;
                    end else begin
                        ram_wr_en_s    = 1'b0;
                    end
                end else if (req_s) begin
                    DCacheMiss = 1'b1;
                    miss_tag_d = req_tag_s;
                    miss_set_d = req_set_s;
                    miss_cnt_d = miss_cnt_q + 32'd1;
                    cnt_d      = {LINE_ADDR_LEN{1'b0}};
                    if (ram_rd_valid_s && ram_rd_dirty_s) begin
                        state_d = WB;
                    end else begin
                        state_d = REFILL;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            WB: begin
                DCacheMiss = 1'b1;
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = {ram_rd_tag_s, miss_set_q, cnt_q, 2'b00};
                mem_wdata  = ram_rd_data_s;
                if (mem_ack) begin
                    cnt_d = cnt_q + LINE_ADDR_LEN'(1);
                    if (cnt_last_s) begin
                        cnt_d   = {LINE_ADDR_LEN{1'b0}};
                        state_d = REFILL;
                    end else begin
                        state_d = WB;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end

            REFILL: begin
                DCacheMiss = 1'b1;
                mem_req    = 1'b1;
                mem_we     = 1'b0;
                mem_addr   = {miss_tag_q, miss_set_q, cnt_q, 2'b00};
                if (mem_ack) begin
                    ram_wr_en_s   = 1'b1;
                    ram_wr_be_s   = 4'b1111;
                    ram_wr_set_s  = miss_set_q;
                    ram_wr_word_s = cnt_q;
                    ram_wr_data_s = mem_rdata;
                    cnt_d         = cnt_q + LINE_ADDR_LEN'(1);
                    if (cnt_last_s) begin
                        ram_fill_en_s = 1'b1;
                        state_d       = IDLE;
                    end else begin
                        state_d       = REFILL;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = {LINE_ADDR_LEN{1'b0}};
            end
        endcase
    end

    // FSM, word counter, latched miss address and miss counter registers.
    always_ff @(posedge clk) begin
        if (CpuRst) begin
            state_q    <= IDLE;
            cnt_q      <= {LINE_ADDR_LEN{1'b0}};
            miss_tag_q <= {TAG_ADDR_LEN{1'b0}};
            miss_set_q <= {SET_ADDR_LEN{1'b0}};
            miss_cnt_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            miss_tag_q <= miss_tag_d;
            miss_set_q <= miss_set_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Randomized scoreboard bench for dcache_miss_ctrl (default geometry:
// 16 sets x 8 words). A reference cache model predicts memory traffic,
// load data, stall length and miss count; a monitor checks them.
module tb_dcache_miss_ctrl;

    logic        clk = 1'b0;
    logic        CpuRst;
    logic        rd_req, wr_req;
    logic [31:0] addr, wr_data;
    logic [3:0]  wr_be;
    logic [31:0] rd_data;
    logic        DCacheMiss;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic [31:0] miss_cnt;

    always #5 clk = ~clk;

    dcache_miss_ctrl dut (
        .clk        (clk),
        .CpuRst     (CpuRst),
        .rd_req     (rd_req),
        .wr_req     (wr_req),
        .addr       (addr),
        .wr_data    (wr_data),
        .wr_be      (wr_be),
        .rd_data    (rd_data),
        .DCacheMiss (DCacheMiss),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .miss_cnt   (miss_cnt)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_exp_t;

    typedef struct {
        logic        is_load;
        logic [31:0] rdata;
        int          stall;
        logic [31:0] mcnt;
    } txn_t;

    mem_exp_t exp_mem[$];
    txn_t     txq[$];

    int n_checks = 0;
    int n_pass   = 0;
    int stall_run = 0;
    int ack_delay = 0;

    // Memory image seen by the DUT and the model's own view of memory.
    logic [31:0] mem_img [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    // Reference cache state
    logic [31:0] m_line [16][8];
    logic [31:0] m_tag  [16];
    bit          m_valid[16];
    bit          m_dirty[16];
    logic [31:0] m_misses;

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return (a * 32'h0001_0DCD) ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] img_rd(input logic [31:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return mem_init(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return mem_init(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %08h required %08h", name, act, exp);
    endtask

    task automatic summary_and_finish();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    endtask

    task automatic model_reset();
        for (int s = 0; s < 16; s++) begin
            m_valid[s] = 1'b0;
            m_dirty[s] = 1'b0;
        end
        m_misses = 32'd0;
    endtask

    // Reference model: predicts the whole effect of one access.
    task automatic model_access(input bit st, input logic [31:0] a,
                                input logic [31:0] wd, input logic [3:0] be);
        int          set, word, stall;
        logic [31:0] tag, base;
        mem_exp_t    e;
        txn_t        t;
        set   = int'((a >> 5) & 32'hF);
        word  = int'((a >> 2) & 32'h7);
        tag   = a >> 9;
        stall = 0;
        if (!(m_valid[set] && m_tag[set] == tag)) begin
            m_misses = m_misses + 32'd1;
            stall = 1 + 8 * (ack_delay + 1);
            if (m_valid[set] && m_dirty[set]) begin
                base = (m_tag[set] << 9) | (32'(set) << 5);
                for (int i = 0; i < 8; i++) begin
                    e.we = 1'b1; e.addr = base + 32'(4 * i); e.wdata = m_line[set][i];
                    exp_mem.push_back(e);
                    ref_mem[e.addr] = e.wdata;
                end
                stall += 8 * (ack_delay + 1);
            end
            base = (tag << 9) | (32'(set) << 5);
            for (int i = 0; i < 8; i++) begin
                e.we = 1'b0; e.addr = base + 32'(4 * i); e.wdata = 32'd0;
                exp_mem.push_back(e);
                m_line[set][i] = ref_rd(e.addr);
            end
            m_valid[set] = 1'b1;
            m_tag[set]   = tag;
            m_dirty[set] = 1'b0;
        end
        if (st) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) m_line[set][word][8*b +: 8] = wd[8*b +: 8];
            m_dirty[set] = 1'b1;
            t.is_load = 1'b0;
            t.rdata   = 32'd0;
        end else begin
            t.is_load = 1'b1;
            t.rdata   = m_line[set][word];
        end
        t.stall = stall;
        t.mcnt  = m_misses;
        txq.push_back(t);
    endtask

    // Memory responder: acks each word after ack_delay wait cycles.
    initial begin
        int wait_left;
        wait_left = -1;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (mem_req === 1'b1) begin
                if (wait_left < 0) wait_left = ack_delay;
                if (wait_left == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = img_rd(mem_addr);
                    if (mem_we) mem_img[mem_addr] = mem_wdata;
                    wait_left = -1;
                end else begin
                    wait_left--;
                end
            end else begin
                wait_left = -1;
            end
        end
    end

    // Monitor: checks memory traffic every requesting cycle and each completed access.
    always @(negedge clk) begin
        mem_exp_t e;
        txn_t     t;
        if (CpuRst === 1'b0) begin
            if (mem_req === 1'b1) begin
                if (exp_mem.size() == 0) begin
                    chk("mem_unexpected_req", 32'(mem_addr), 32'hFFFF_FFFF);
                end else begin
                    e = exp_mem[0];
                    chk("mem_we", 32'(mem_we), 32'(e.we));
                    chk("mem_addr", mem_addr, e.addr);
                    if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
                    if (mem_ack) void'(exp_mem.pop_front());
                end
            end
            if ((rd_req | wr_req) === 1'b1) begin
                if (DCacheMiss) begin
                    stall_run++;
                end else if (txq.size() == 0) begin
                    chk("unexpected_completion", 32'(stall_run), 32'hFFFF_FFFF);
                end else begin
                    t = txq.pop_front();
                    chk("stall_cycles", 32'(stall_run), 32'(t.stall));
                    chk("miss_cnt", miss_cnt, t.mcnt);
                    if (t.is_load) chk("rd_data", rd_data, t.rdata);
                    stall_run = 0;
                end
            end
        end
    end

    // Issue one access and hold it until DCacheMiss drops (bounded).
    task automatic do_access(input bit st, input bit ld, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] be);
        bit ok;
        model_access(st, a, wd, be);
        @(posedge clk);
        #1;
        rd_req = ld; wr_req = st; addr = a; wr_data = wd; wr_be = be;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (DCacheMiss === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        rd_req = 1'b0; wr_req = 1'b0;
        addr = $urandom; wr_data = $urandom; wr_be = 4'(($urandom));
        if (!ok) begin
            n_checks++;
            $display("FAIL access_timeout: addr %08h still stalled after 400 cycles", a);
            summary_and_finish();
        end
    endtask

    initial begin
        logic [31:0] a;
        int          kind;
        bit          found;
        CpuRst = 1'b1;
        rd_req = 1'b0; wr_req = 1'b0;
        addr = 32'd0; wr_data = 32'd0; wr_be = 4'b0000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        CpuRst = 1'b0;

        @(negedge clk);
        chk("rst_DCacheMiss", 32'(DCacheMiss), 32'd0);
        chk("rst_mem_req",    32'(mem_req),    32'd0);
        chk("rst_mem_we",     32'(mem_we),     32'd0);
        chk("rst_mem_addr",   mem_addr,        32'd0);
        chk("rst_mem_wdata",  mem_wdata,       32'd0);
        chk("rst_miss_cnt",   miss_cnt,        32'd0);

        // Cold load, store hit, reload, dirty eviction, simultaneous rd/wr.
        do_access(1'b0, 1'b1, 32'h0000_0100, 32'd0, 4'b0000);
        do_access(1'b1, 1'b0, 32'h0000_0104, 32'hDEAD_BEEF, 4'b0011);
        do_access(1'b0, 1'b1, 32'h0000_0104, 32'd0, 4'b0000);
        do_access(1'b0, 1'b1, 32'h0000_0904, 32'd0, 4'b0000);
        do_access(1'b1, 1'b1, 32'h0000_0908, 32'h1234_5678, 4'b1111);
        do_access(1'b0, 1'b1, 32'h0000_0104, 32'd0, 4'b0000);

        // Wait states on clean and dirty misses.
        ack_delay = 3;
        do_access(1'b0, 1'b1, 32'h0000_1104, 32'd0, 4'b0000);
        do_access(1'b1, 1'b0, 32'h0000_1104, 32'hCAFE_F00D, 4'b1100);
        do_access(1'b0, 1'b1, 32'h0000_1304, 32'd0, 4'b0000);

        // Random mix over a small tag pool so sets are evicted often.
        for (int n = 0; n < 200; n++) begin
            ack_delay = int'($urandom_range(0, 2));
            a = ({30'd0, 2'($urandom_range(0, 3))} << 9) | (32'($urandom_range(0, 15)) << 5)
                | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            kind = int'($urandom_range(0, 2));
            do_access(kind != 0, kind != 1, a, $urandom, 4'($urandom_range(1, 15)));
        end

        // Reset during refill word 4, then reload the same address.
        ack_delay = 0;
        a = 32'h0000_0EA8;
        model_access(1'b0, a, 32'd0, 4'b0000);
        @(posedge clk);
        #1;
        rd_req = 1'b1; addr = a;
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (mem_req === 1'b1 && mem_we === 1'b0 && mem_addr[4:2] == 3'd4) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            n_checks++;
            $display("FAIL refill_word4_timeout: refill of %08h never reached word 4", a);
            summary_and_finish();
        end
        CpuRst = 1'b1;
        rd_req = 1'b0;
        @(posedge clk);
        #1;
        CpuRst = 1'b0;
        exp_mem.delete();
        txq.delete();
        stall_run = 0;
        model_reset();
        @(negedge clk);
        chk("midrst_mem_req",    32'(mem_req),    32'd0);
        chk("midrst_DCacheMiss", 32'(DCacheMiss), 32'd0);
        chk("midrst_miss_cnt",   miss_cnt,        32'd0);
        do_access(1'b0, 1'b1, a, 32'd0, 4'b0000);

        repeat (5) @(posedge clk);
        chk("mem_queue_drained", 32'(exp_mem.size()), 32'd0);
        chk("txn_queue_drained", 32'(txq.size()), 32'd0);
        summary_and_finish();
    end

endmodule
